// File: rtl/patch_injector.sv
// Injects fake 16-bit read data from the patch store onto the RAM data bus
// during triggered read bursts, after skipping a configurable number of beats.
module patch_injector #(
   parameter logic [15:0] CONFIG_ADDR = 16'h7010
) (
   input  logic        mclk,
   input  logic        reset,
   input  logic [15:0] config_addr,
   input  logic [15:0] config_data,
   input  logic        config_strobe,
   input  logic        patch_trigger,
   input  logic        burst_is_read,
   input  logic        burst_end,
   input  logic        beat_strobe,
   input  logic [15:0] patch_data,
   output logic        patch_data_next,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   output logic [15:0] patch_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2,
      TAIL  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        cfg_en_q, cfg_en_d;
   logic [3:0]  cfg_lat_q, cfg_lat_d;
   logic [7:0]  cfg_max_q, cfg_max_d;
   logic [3:0]  lat_cnt_q, lat_cnt_d;
   logic [7:0]  max_q, max_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [15:0] dq_out_q, dq_out_d;
   logic        dq_oe_q, dq_oe_d;
   logic [15:0] patch_count_q, patch_count_d;

   logic        accept;
   logic        cfg_write;
   logic [7:0]  word_cnt_inc;
   logic        unused_cfg_bits;

   assign unused_cfg_bits = ^config_data[7:5];

   assign cfg_write    = config_strobe && (config_addr == CONFIG_ADDR);
   assign accept       = patch_trigger && cfg_en_q && burst_is_read;
   assign word_cnt_inc = word_cnt_q + 8'd1;

   // A beat swallowed by a restart or abort must not advance the patch store.
   assign patch_data_next = beat_strobe && (state_q == DRIVE) && !accept && !burst_end;

   assign dq_out      = dq_out_q;
   assign dq_oe       = dq_oe_q;
   assign patch_count = patch_count_q;

   always_comb begin
      state_d       = state_q;
      cfg_en_d      = cfg_en_q;
      cfg_lat_d     = cfg_lat_q;
      cfg_max_d     = cfg_max_q;
      lat_cnt_d     = lat_cnt_q;
      max_d         = max_q;
      word_cnt_d    = word_cnt_q;
      dq_out_d      = dq_out_q;
      dq_oe_d       = dq_oe_q;
      patch_count_d = patch_count_q;

      if (cfg_write) begin
         cfg_en_d  = config_data[0];
         cfg_lat_d = config_data[4:1];
         cfg_max_d = config_data[15:8];
      end

      if (accept) begin
         if (patch_count_q != 16'hFFFF)
            patch_count_d = patch_count_q + 16'd1;
         lat_cnt_d  = cfg_lat_q;
         max_d      = cfg_max_q;
         word_cnt_d = 8'd0;
         dq_oe_d    = 1'b0;
         state_d    = (cfg_lat_q != 4'd0) ? WAIT : DRIVE;
      end else if (burst_end && (state_q != IDLE)) begin
         dq_oe_d = 1'b0;
         state_d = IDLE;
      end else if (beat_strobe) begin
         case (state_q)
            WAIT: begin
               lat_cnt_d = lat_cnt_q - 4'd1;
               if (lat_cnt_q == 4'd1)
                  state_d = DRIVE;
            end
            DRIVE: begin
               dq_out_d   = patch_data;
               dq_oe_d    = 1'b1;
               word_cnt_d = word_cnt_inc;
               // max of zero means unlimited; the word counter simply wraps.
               if ((max_q != 8'd0) && (word_cnt_inc == max_q))
                  state_d = TAIL;
            end
            TAIL: begin
               dq_oe_d = 1'b0;
               state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cfg_en_q      <= 1'b0;
         cfg_lat_q     <= 4'd0;
         cfg_max_q     <= 8'd0;
         lat_cnt_q     <= 4'd0;
         max_q         <= 8'd0;
         word_cnt_q    <= 8'd0;
         dq_out_q      <= 16'd0;
         dq_oe_q       <= 1'b0;
         patch_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         cfg_en_q      <= cfg_en_d;
         cfg_lat_q     <= cfg_lat_d;
         cfg_max_q     <= cfg_max_d;
         lat_cnt_q     <= lat_cnt_d;
         max_q         <= max_d;
         word_cnt_q    <= word_cnt_d;
         dq_out_q      <= dq_out_d;
         dq_oe_q       <= dq_oe_d;
         patch_count_q <= patch_count_d;
      end
   end

endmodule

// File: tb/tb_patch_injector.sv
// Directed bench for patch_injector: a small patch-store model supplies
// patch_data and advances on patch_data_next; expectations are hand-computed.
module tb_patch_injector;

   logic        mclk;
   logic        reset;
   logic [15:0] config_addr;
   logic [15:0] config_data;
   logic        config_strobe;
   logic        patch_trigger;
   logic        burst_is_read;
   logic        burst_end;
   logic        beat_strobe;
   logic [15:0] patch_data;
   logic        patch_data_next;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic [15:0] patch_count;

   int n_assert;
   int n_fail;
   logic [15:0] pd_idx;

   patch_injector dut (
      .mclk            (mclk),
      .reset           (reset),
      .config_addr     (config_addr),
      .config_data     (config_data),
      .config_strobe   (config_strobe),
      .patch_trigger   (patch_trigger),
      .burst_is_read   (burst_is_read),
      .burst_end       (burst_end),
      .beat_strobe     (beat_strobe),
      .patch_data      (patch_data),
      .patch_data_next (patch_data_next),
      .dq_out          (dq_out),
      .dq_oe           (dq_oe),
      .patch_count     (patch_count)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Patch store model: word = 0x00A0 + address, address advances on request.
   always_ff @(posedge mclk) begin
      if (patch_data_next)
         pd_idx <= pd_idx + 16'd1;
   end
   assign patch_data = 16'h00A0 + pd_idx;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
      patch_trigger = 1'b0;
      beat_strobe   = 1'b0;
      burst_end     = 1'b0;
      config_strobe = 1'b0;
   endtask

   task automatic cfg(input logic [15:0] addr, input logic [15:0] data);
      config_addr   = addr;
      config_data   = data;
      config_strobe = 1'b1;
      tick();
   endtask

   task automatic trig(input logic is_read);
      patch_trigger = 1'b1;
      burst_is_read = is_read;
      tick();
   endtask

   // One beat: check the same-cycle advance request, then the registered enable.
   task automatic beat(input string tag, input logic exp_next, input logic exp_oe);
      beat_strobe = 1'b1;
      @(negedge mclk);
      chk({tag, "_next"}, {15'd0, patch_data_next}, {15'd0, exp_next});
      tick();
      chk({tag, "_oe"}, {15'd0, dq_oe}, {15'd0, exp_oe});
   endtask

   logic [15:0] start_idx;

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      pd_idx        = 16'd0;
      reset         = 1'b1;
      config_addr   = 16'd0;
      config_data   = 16'd0;
      config_strobe = 1'b0;
      patch_trigger = 1'b0;
      burst_is_read = 1'b0;
      burst_end     = 1'b0;
      beat_strobe   = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_oe", {15'd0, dq_oe}, 16'd0);
      chk("rst_dq", dq_out, 16'd0);
      chk("rst_cnt", patch_count, 16'd0);
      chk("rst_next", {15'd0, patch_data_next}, 16'd0);
      reset = 1'b0;
      tick();

      // Latency: enable, lat=2, max=0; beats 3..5 drive A0, A1, A2
      cfg(16'h7010, 16'h0005);
      trig(1'b1);
      beat("lat_b1", 1'b0, 1'b0); tick(); tick();
      beat("lat_b2", 1'b0, 1'b0); tick(); tick();
      beat("lat_b3", 1'b1, 1'b1);
      chk("lat_dq3", dq_out, 16'h00A0);
      tick(); tick();
      beat("lat_b4", 1'b1, 1'b1);
      chk("lat_dq4", dq_out, 16'h00A1);
      tick(); tick();
      beat("lat_b5", 1'b1, 1'b1);
      chk("lat_dq5", dq_out, 16'h00A2);
      chk("lat_pulses", pd_idx, 16'd3);
      chk("lat_count", patch_count, 16'd1);
      burst_end = 1'b1;
      tick();
      chk("lat_end_oe", {15'd0, dq_oe}, 16'd0);
      chk("lat_end_dq", dq_out, 16'h00A2);

      // Max limit: lat=0, max=2, four back-to-back beats
      cfg(16'h7010, 16'h0201);
      start_idx = pd_idx;
      trig(1'b1);
      beat("max_b1", 1'b1, 1'b1);
      beat("max_b2", 1'b1, 1'b1);
      beat("max_b3", 1'b0, 1'b0);
      beat("max_b4", 1'b0, 1'b0);
      chk("max_pulses", pd_idx - start_idx, 16'd2);
      chk("max_dq", dq_out, 16'h00A4);
      chk("max_count", patch_count, 16'd2);

      // Filtering: write trigger, then read trigger while disabled
      trig(1'b0);
      beat("flt_wr", 1'b0, 1'b0);
      cfg(16'h7010, 16'h0004);
      trig(1'b1);
      beat("flt_dis", 1'b0, 1'b0);
      cfg(16'h7011, 16'h0001);
      trig(1'b1);
      beat("flt_addr", 1'b0, 1'b0);
      chk("flt_count", patch_count, 16'd2);

      // Abort mid-DRIVE, then restart coincident with burst_end
      cfg(16'h7010, 16'h0001);
      trig(1'b1);
      beat("abt_b1", 1'b1, 1'b1);
      chk("abt_dq", dq_out, 16'h00A5);
      burst_end = 1'b1;
      tick();
      chk("abt_oe", {15'd0, dq_oe}, 16'd0);
      beat("abt_idle", 1'b0, 1'b0);
      trig(1'b1);
      beat("rst_b1", 1'b1, 1'b1);
      patch_trigger = 1'b1;
      burst_is_read = 1'b1;
      burst_end     = 1'b1;
      tick();
      chk("rs_oe", {15'd0, dq_oe}, 16'd0);
      chk("rs_count", patch_count, 16'd5);
      beat("rs_b1", 1'b1, 1'b1);
      chk("rs_dq", dq_out, 16'h00A7);

      // Saturation: 65536 more accepts, then one more
      patch_trigger = 1'b1;
      burst_is_read = 1'b1;
      repeat (65536) @(posedge mclk);
      #1;
      patch_trigger = 1'b0;
      chk("sat_full", patch_count, 16'hFFFF);
      trig(1'b1);
      chk("sat_hold", patch_count, 16'hFFFF);

      // Asynchronous reset mid-DRIVE
      beat("ar_b1", 1'b1, 1'b1);
      beat_strobe = 1'b1;
      @(negedge mclk);
      reset = 1'b1;
      #1;
      chk("ar_oe", {15'd0, dq_oe}, 16'd0);
      chk("ar_dq", dq_out, 16'd0);
      chk("ar_cnt", patch_count, 16'd0);
      chk("ar_next", {15'd0, patch_data_next}, 16'd0);
      tick();
      reset = 1'b0;
      tick();
      trig(1'b1);
      beat("ar_ign", 1'b0, 1'b0);
      chk("ar_ign_cnt", patch_count, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
